// File: rtl/lamp_sequence_monitor.sv
// Receive-side checker for the one-hot traffic-lamp bus: tracks GREEN -> YELLOW -> RED -> GREEN
// and flags illegal codes, out-of-order transitions and over-long dwell.
module lamp_sequence_monitor #(
  parameter int unsigned MAX_DWELL = 4,
  parameter int unsigned DWELL_W   = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [0:2]       light,
  input  logic             clear,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             illegal_code,
  output logic             seq_error,
  output logic             dwell_error,
  output logic             err_sticky,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [1:0] PhGreen  = 2'd0;
  localparam logic [1:0] PhYellow = 2'd1;
  localparam logic [1:0] PhRed    = 2'd2;
  localparam logic [1:0] PhNone   = 2'd3;

  localparam logic [DWELL_W-1:0] MaxDwell = DWELL_W'(MAX_DWELL);
  localparam logic [DWELL_W-1:0] DwellOne = DWELL_W'(1);
  localparam logic [CNT_W-1:0]   CntMax   = '1;
  localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e             state_q;
  logic [1:0]         phase_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               illegal_q;
  logic               seq_err_q;
  logic               dwell_err_q;
  logic               sticky_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   cyc_cnt_q;

  logic       code_legal;
  logic [1:0] code_phase;
  logic [1:0] succ_phase;
  logic       same_code;
  logic       illegal_d;
  logic       seq_err_d;
  logic       dwell_err_d;
  logic       err_d;

  // light[0] is the red bit, so 3'b100 reads as RED on this [0:2] bus.
  always_comb begin
    code_legal = 1'b1;
    code_phase = PhNone;
    unique case (light)
      3'b100:  code_phase = PhRed;
      3'b010:  code_phase = PhGreen;
      3'b001:  code_phase = PhYellow;
      default: code_legal = 1'b0;
    endcase
  end

  always_comb begin
    succ_phase = PhNone;
    unique case (phase_q)
      PhGreen:  succ_phase = PhYellow;
      PhYellow: succ_phase = PhRed;
      PhRed:    succ_phase = PhGreen;
      default:  succ_phase = PhNone;
    endcase
  end

  always_comb begin
    same_code   = (state_q == StLocked) && code_legal && (code_phase == phase_q);
    illegal_d   = ~code_legal;
    dwell_err_d = same_code && (dwell_q == MaxDwell);
    seq_err_d   = (state_q == StLocked) && code_legal && (code_phase != phase_q) &&
                  (code_phase != succ_phase);
    err_d       = illegal_d | seq_err_d | dwell_err_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StUnlocked;
      phase_q     <= PhNone;
      dwell_q     <= '0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      dwell_err_q <= 1'b0;
      sticky_q    <= 1'b0;
      err_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
    end else begin
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      dwell_err_q <= dwell_err_d;

      unique case (state_q)
        StUnlocked: begin
          if (code_legal) begin
            state_q <= StLocked;
            phase_q <= code_phase;
            dwell_q <= DwellOne;
          end else begin
            phase_q <= PhNone;
            dwell_q <= '0;
          end
        end
        StLocked: begin
          if (!code_legal || dwell_err_d) begin
            state_q <= StUnlocked;
            phase_q <= PhNone;
            dwell_q <= '0;
          end else if (same_code) begin
            dwell_q <= dwell_q + DwellOne;
          end else begin
            // Legal successor or resync on a non-successor; only RED -> GREEN completes a cycle.
            phase_q <= code_phase;
            dwell_q <= DwellOne;
            if (!seq_err_d && (phase_q == PhRed)) begin
              cyc_cnt_q <= cyc_cnt_q + CntOne;
            end
          end
        end
        default: begin
          state_q <= StUnlocked;
          phase_q <= PhNone;
          dwell_q <= '0;
        end
      endcase

      // Clear wins the count, but a same-edge error still leaves the sticky flag set.
      if (clear) begin
        err_cnt_q <= '0;
        sticky_q  <= err_d;
      end else if (err_d) begin
        sticky_q <= 1'b1;
        if (err_cnt_q != CntMax) begin
          err_cnt_q <= err_cnt_q + CntOne;
        end
      end
    end
  end

  assign phase        = phase_q;
  assign locked       = (state_q == StLocked);
  assign illegal_code = illegal_q;
  assign seq_error    = seq_err_q;
  assign dwell_error  = dwell_err_q;
  assign err_sticky   = sticky_q;
  assign error_count  = err_cnt_q;
  assign cycle_count  = cyc_cnt_q;

  pulses_exclusive_a: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0({illegal_q, seq_err_q, dwell_err_q}));

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Table-driven bench for lamp_sequence_monitor: expected outputs are queued as stimulus is driven
// and compared one edge later.
module tb_lamp_sequence_monitor;

  localparam logic [0:2] LG = 3'b010;
  localparam logic [0:2] LY = 3'b001;
  localparam logic [0:2] LR = 3'b100;

  typedef struct packed {
    logic [1:0] phase;
    logic       locked;
    logic       ill;
    logic       seq;
    logic       dwl;
    logic       sticky;
    logic [7:0] ec;
    logic [7:0] cc;
  } exp_t;

  typedef struct {
    string      name;
    logic [0:2] light;
    logic       clear;
    exp_t       exp;
  } vec_t;

  logic       clock;
  logic       reset_n;
  logic [0:2] light;
  logic       clear;
  logic [1:0] phase;
  logic       locked;
  logic       illegal_code;
  logic       seq_error;
  logic       dwell_error;
  logic       err_sticky;
  logic [7:0] error_count;
  logic [7:0] cycle_count;

  int pass_cnt;
  int total_cnt;
  vec_t exp_q[$];
  vec_t table_v[$];

  lamp_sequence_monitor #(
    .MAX_DWELL(4),
    .DWELL_W  (4),
    .CNT_W    (8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .light       (light),
    .clear       (clear),
    .phase       (phase),
    .locked      (locked),
    .illegal_code(illegal_code),
    .seq_error   (seq_error),
    .dwell_error (dwell_error),
    .err_sticky  (err_sticky),
    .error_count (error_count),
    .cycle_count (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input string name, input logic [0:2] l, input logic c,
                              input logic [1:0] ph, input logic lk, input logic ill,
                              input logic seq, input logic dwl, input logic st,
                              input logic [7:0] ec, input logic [7:0] cc);
    vec_t v;
    v.name  = name;
    v.light = l;
    v.clear = c;
    v.exp   = '{phase: ph, locked: lk, ill: ill, seq: seq, dwl: dwl, sticky: st, ec: ec, cc: cc};
    return v;
  endfunction

  task automatic compare(input string name, input exp_t e);
    exp_t got;
    got = {phase, locked, illegal_code, seq_error, dwell_error, err_sticky, error_count,
           cycle_count};
    total_cnt++;
    if (got === e) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got ph=%0d lk=%0b ill=%0b seq=%0b dwl=%0b st=%0b ec=%0d cc=%0d, want ph=%0d lk=%0b ill=%0b seq=%0b dwl=%0b st=%0b ec=%0d cc=%0d",
               name, got.phase, got.locked, got.ill, got.seq, got.dwl, got.sticky, got.ec,
               got.cc, e.phase, e.locked, e.ill, e.seq, e.dwl, e.sticky, e.ec, e.cc);
    end
  endtask

  // Inputs change 1ns after a rising edge; the result is checked 1ns after the next one.
  task automatic drive(input vec_t v);
    vec_t e;
    light = v.light;
    clear = v.clear;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    compare(e.name, e.exp);
  endtask

  initial begin
    logic [0:2] lamps[3];
    logic [0:2] bad[5];
    vec_t e;
    int ec;
    lamps = '{LG, LY, LR};
    bad   = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    pass_cnt  = 0;
    total_cnt = 0;

    // Table: normal cycling, illegal code, dwell overrun, out-of-order transition.
    for (int i = 0; i < 12; i++) begin
      table_v.push_back(mk("t1_cycle", lamps[i % 3], 1'b0, 2'(i % 3), 1'b1, 1'b0, 1'b0, 1'b0,
                           1'b0, 8'd0, 8'(i / 3)));
    end
    table_v.push_back(mk("t2_illegal", 3'b110, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd3));
    table_v.push_back(mk("t2_relock", LG, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd3));
    for (int i = 0; i < 3; i++) begin
      table_v.push_back(mk("t3_hold", LG, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd3));
    end
    table_v.push_back(mk("t3_dwell_err", LG, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 8'd3));
    table_v.push_back(mk("t3_relock", LG, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 8'd3));
    table_v.push_back(mk("t4_seq_err", LR, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 8'd3));
    table_v.push_back(mk("t4_red_green", LG, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'd4));

    reset_n = 1'b0;
    light   = 3'b000;
    clear   = 1'b0;
    #12;
    e = mk("reset_state", 3'b000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    compare(e.name, e.exp);
    reset_n = 1'b1;

    for (int i = 0; i < table_v.size(); i++) begin
      drive(table_v[i]);
    end

    // Error counter saturation over a long illegal run.
    for (int k = 1; k <= 300; k++) begin
      ec = (3 + k > 255) ? 255 : 3 + k;
      drive(mk("t5_saturate", bad[k % 5], 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'(ec), 8'd4));
    end
    drive(mk("t5_clear_err", 3'b111, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd4));
    drive(mk("t5_clear_ok", LG, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4));
    drive(mk("t6_yellow", LY, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4));

    // Asynchronous reset asserted and released between edges while locked in YELLOW.
    clear = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    e = mk("t6_async_reset", 3'b000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    compare(e.name, e.exp);
    #3;
    reset_n = 1'b1;
    drive(mk("t6_relock_red", LR, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));

    // cycle_count wraps from 255 back to 0.
    for (int n = 1; n <= 256; n++) begin
      drive(mk("t7_wrap_g", LG, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'(n)));
      drive(mk("t7_wrap_y", LY, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'(n)));
      drive(mk("t7_wrap_r", LR, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'(n)));
    end
    drive(mk("t7_nonsucc", LY, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0));
    drive(mk("t7_clear_seq", LG, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lamp_sequence_monitor.md
Name: lamp_sequence_monitor

Overview:
- Receive-side checker for the 3-bit one-hot traffic-lamp bus driven by the cyclic lamp controller.
- Decodes the lamp code every clock and tracks the legal cycle GREEN -> YELLOW -> RED -> GREEN.
- Flags illegal codes, out-of-order transitions and over-long dwell.
- Sits beside the lamp driver and feeds a status/error register block.

Parameters:
- MAX_DWELL, 4: maximum consecutive cycles one lamp code may be held. A hold of MAX_DWELL+1 cycles is an error. Legal range 1..(2**DWELL_W)-2.
- DWELL_W, 4: width of the internal dwell counter.
- CNT_W, 8: width of error_count and cycle_count.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- light  input  [0:2]  lamp bus. 3'b100=RED, 3'b010=GREEN, 3'b001=YELLOW. light[0] is the red bit.
- clear  input  1  synchronous clear of error_count and err_sticky.
- phase  output  2  decoded phase: 0=GREEN, 1=YELLOW, 2=RED, 3=NONE.
- locked  output  1  monitor is synchronised to a legal code.
- illegal_code  output  1  one-cycle pulse: light is not one of the three legal codes.
- seq_error  output  1  one-cycle pulse: legal code, but not the legal successor.
- dwell_error  output  1  one-cycle pulse: code held MAX_DWELL+1 cycles.
- err_sticky  output  1  set by any error pulse; cleared only by clear or reset.
- error_count  output  CNT_W  saturating count of error pulses.
- cycle_count  output  CNT_W  wrapping count of completed RED -> GREEN transitions while locked.

Behaviour:

Reset (reset_n low, asynchronous):
- phase=3, locked=0, all pulses 0, err_sticky=0, error_count=0, cycle_count=0, dwell=0.
- Applies immediately, including mid-cycle. After release the monitor re-acquires from UNLOCKED.

Timing:
- All outputs are registered.
- light is sampled at rising edge N. Outputs reflecting that sample are valid after edge N (one-edge latency). No combinational path from light to any output.

Decode:
- Exactly the three legal codes above.
- 3'b000, 3'b011, 3'b101, 3'b110 and 3'b111 are illegal.

State machine (two states, UNLOCKED and LOCKED):
- UNLOCKED, legal code: go to LOCKED, phase=decoded, dwell=1, no error.
- UNLOCKED, illegal code: illegal_code=1, stay UNLOCKED, phase=3.
- LOCKED, same code as phase, dwell<MAX_DWELL: dwell+1, no error.
- LOCKED, same code as phase, dwell==MAX_DWELL: dwell_error=1, go to UNLOCKED, phase=3, dwell=0.
- LOCKED, legal successor (GREEN->YELLOW, YELLOW->RED, RED->GREEN): phase=new, dwell=1.
  - If the transition is RED->GREEN, cycle_count+1, wrapping from all-ones to 0.
- LOCKED, legal non-successor (e.g. GREEN->RED): seq_error=1, phase=new, dwell=1, stay LOCKED (resync). cycle_count unchanged.
- LOCKED, illegal code: illegal_code=1, go to UNLOCKED, phase=3, dwell=0.
- locked = (state==LOCKED).

Errors:
- The three pulses are mutually exclusive; at most one fires per cycle.
- Any pulse sets err_sticky and increments error_count.
- error_count saturates at 2**CNT_W-1.
- clear forces error_count=0 and err_sticky=0 on that edge.
  - If an error pulse occurs on the same edge, clear wins the count (0), but the pulse output is still asserted and err_sticky ends at 1.
- clear does not affect state, phase, dwell or cycle_count.

Test Plan:
1. Reset, then light = GREEN, YELLOW, RED repeated for 4 full cycles, one cycle each:
   - locked=1 after the first edge, phase follows 0,1,2.
   - cycle_count=3 after the 4th GREEN.
   - No error pulses; error_count=0.
2. Locked, then drive light=3'b110 for one cycle:
   - illegal_code=1 for one cycle, locked=0, phase=3, err_sticky=1, error_count=1.
   - Next GREEN relocks with phase=0.
3. Drive GREEN for 5 consecutive cycles with MAX_DWELL=4:
   - dwell_error pulses on the 5th edge, locked=0.
   - A 6th GREEN relocks with no error.
4. Locked in GREEN, then drive RED:
   - seq_error=1 for one cycle, phase=2, locked stays 1.
   - Following GREEN increments cycle_count with no error.
5. Force 300 illegal cycles with CNT_W=8:
   - error_count saturates at 255.
   - Assert clear on the same edge as an illegal sample: error_count=0, err_sticky=1, illegal_code=1.
6. Assert reset_n low asynchronously between edges while locked in YELLOW:
   - All outputs return to reset values immediately.
   - After release, the first RED locks with phase=2 and seq_error is not flagged.
